// File: rtl/vx_mem_req_limiter_pkg.sv
// Shared types and constants for the memory request limiter.
// Holds the drain FSM encoding and the perf counter width.
package vx_mem_req_limiter_pkg;

  typedef enum logic [1:0] {
    LIM_RUN   = 2'd0,
    LIM_DRAIN = 2'd1,
    LIM_DONE  = 2'd2
  } lim_state_e;

  localparam int LIM_PERF_CTR_W          = 32;
  localparam int LIM_MAX_PENDING_DEFAULT = 16;

  function automatic int cnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/vx_mem_req_limiter_if.sv
// Line-wide memory bus: request channel downstream, response channel upstream.
interface vx_mem_req_limiter_if #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8
);

  logic                    req_valid;
  logic                    req_rw;
  logic [DATA_SIZE-1:0]    req_byteen;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_SIZE*8-1:0]  req_data;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic                    req_ready;

  logic                    rsp_valid;
  logic [DATA_SIZE*8-1:0]  rsp_data;
  logic [TAG_WIDTH-1:0]    rsp_tag;
  logic                    rsp_ready;

  modport master (
    output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );

endinterface

// File: rtl/vx_mem_req_limiter_rsp_buf.sv
// Elastic FIFO for the response path: one-cycle latency, one item per cycle.
// Input ready depends only on occupancy, so no combinational ready path crosses it.
module vx_mem_req_limiter_rsp_buf
  import vx_mem_req_limiter_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int SIZE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out
);

  localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = $clog2(SIZE + 1);

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DATAW-1:0] entry_vals [SIZE];
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ready_in  = (count_reg != CNT_W'(SIZE));
  assign valid_out = (count_reg != '0);
  assign push      = valid_in && ready_in;
  assign pop       = valid_out && ready_out;
  assign data_out  = entry_vals[rd_ptr_reg];

  // Storage carries no reset; occupancy alone decides what is valid.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_entry
    logic [DATAW-1:0] entry_reg;
    always_ff @(posedge clk) begin
      if (push && wr_ptr_reg == PTR_W'(gi)) begin
        entry_reg <= data_in;
      end
    end
    assign entry_vals[gi] = entry_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/vx_mem_req_limiter.sv
// Caps outstanding reads toward memory, lets writes through, and buffers responses.
// A flush request drains all outstanding reads and then reports completion.
module vx_mem_req_limiter
  import vx_mem_req_limiter_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_WIDTH    = 8,
  parameter int MAX_PENDING  = LIM_MAX_PENDING_DEFAULT,
  parameter int RSP_BUF_SIZE = 2,
  localparam int CNT_W       = cnt_width(MAX_PENDING)
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_mem_req_limiter_if.slave       bus_in_if,
  vx_mem_req_limiter_if.master      bus_out_if,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic [CNT_W-1:0]          pending_count,
  output logic [LIM_PERF_CTR_W-1:0] stall_cycles
);

  localparam int RSP_W = DATA_SIZE * 8 + TAG_WIDTH;

  lim_state_e                state_reg;
  logic                      flush_done_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [LIM_PERF_CTR_W-1:0] stall_reg;
  logic                      allow, rd_fire, rsp_fire_in, rsp_fire_out;
  logic [RSP_W-1:0]          rsp_buf_out;

  assign allow = (state_reg == LIM_RUN)
              && (bus_in_if.req_rw || (cnt_reg < CNT_W'(MAX_PENDING)));

  assign bus_out_if.req_valid  = bus_in_if.req_valid && allow;
  assign bus_out_if.req_rw     = bus_in_if.req_rw;
  assign bus_out_if.req_byteen = bus_in_if.req_byteen;
  assign bus_out_if.req_addr   = bus_in_if.req_addr;
  assign bus_out_if.req_data   = bus_in_if.req_data;
  assign bus_out_if.req_tag    = bus_in_if.req_tag;
  assign bus_in_if.req_ready   = bus_out_if.req_ready && allow;

  assign rd_fire      = bus_out_if.req_valid && bus_out_if.req_ready && !bus_in_if.req_rw;
  assign rsp_fire_in  = bus_in_if.rsp_valid && bus_in_if.rsp_ready;
  assign rsp_fire_out = bus_out_if.rsp_valid && bus_out_if.rsp_ready;

  vx_mem_req_limiter_rsp_buf #(
    .DATAW (RSP_W),
    .SIZE  (RSP_BUF_SIZE)
  ) rsp_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (bus_out_if.rsp_valid),
    .ready_in  (bus_out_if.rsp_ready),
    .data_in   ({bus_out_if.rsp_data, bus_out_if.rsp_tag}),
    .valid_out (bus_in_if.rsp_valid),
    .ready_out (bus_in_if.rsp_ready),
    .data_out  (rsp_buf_out)
  );

  assign {bus_in_if.rsp_data, bus_in_if.rsp_tag} = rsp_buf_out;

  // Credit returns only when the response leaves upstream, so buffered ones stay counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (rd_fire && !rsp_fire_in) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (!rd_fire && rsp_fire_in && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_reg <= '0;
    end else if (bus_in_if.req_valid && !(allow && bus_out_if.req_ready)) begin
      stall_reg <= stall_reg + LIM_PERF_CTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= LIM_RUN;
      flush_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        LIM_RUN: begin
          if (flush_req) state_reg <= LIM_DRAIN;
        end
        LIM_DRAIN: begin
          if (cnt_reg == '0) begin
            state_reg      <= LIM_DONE;
            flush_done_reg <= 1'b1;
          end
        end
        LIM_DONE: begin
          if (!flush_req) begin
            state_reg      <= LIM_RUN;
            flush_done_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= LIM_RUN;
          flush_done_reg <= 1'b0;
        end
      endcase
    end
  end

  // A response with nothing outstanding means the downstream side is broken.
  assert property (@(posedge clk) disable iff (reset) !(rsp_fire_out && cnt_reg == '0));

  assign flush_done    = flush_done_reg;
  assign pending_count = cnt_reg;
  assign stall_cycles  = stall_reg;

endmodule
